// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 slave.
//   state_e          : FSM state encoding (IDLE=0, ACTIVE=1)
//   DATA_WIDTH_DEF   : default bits per frame
//   SYNC_STAGES_DEF  : default synchronizer depth on each SPI input
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Single-bit synchronizer with edge detection.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   d_i    : asynchronous input
//   q_o    : synchronized level (last sync stage)
//   rise_o : one-clk pulse on a synchronized 0->1 transition
//   fall_o : one-clk pulse on a synchronized 1->0 transition
// The chain resets to 0. For chip select this means a cs that is already
// low when reset releases produces no falling edge, so it cannot start a
// frame; a cs that is high produces a rising edge, which IDLE ignores.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~dly_q;
  assign fall_o = ~q_o & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0) slave, fully in the clk domain.
//   clk       : system clock, at least 4x spi_clk
//   reset     : asynchronous active-high reset
//   spi_clk   : serial clock from master (idles low)
//   cs        : chip select, active low
//   mosi      : serial data in, MSB first
//   miso      : serial data out, 1 when not selected
//   tx_data   : word to send, captured at frame start (and on frame wrap)
//   rx_data   : last complete received word
//   rx_valid  : one-clk pulse when rx_data updates
//   busy      : high while selected
//   frame_err : one-clk pulse when cs rises mid-frame
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level_unused, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(clk), .rst_i(reset), .d_i(spi_clk),
    .q_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(clk), .rst_i(reset), .d_i(cs),
    .q_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(clk), .rst_i(reset), .d_i(mosi),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e                  state_q;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    miso_q, rx_valid_q, frame_err_q;
  logic                    done_q;    // frame completed last clk; publish rx_data now
  logic                    reload_q;  // tx word just reloaded; next fall presents its MSB unshifted
  logic                    last_bit;

  always_comb begin
    last_bit   = sclk_rise && (bit_cnt_q == LAST_BIT);
    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
    bit_cnt_d  = bit_cnt_q;
    if (sclk_rise) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b1;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
      reload_q    <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      // Publishing is outside the state case so a frame completed in the
      // same clk as cs rising still delivers its word from IDLE.
      if (done_q) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
        done_q     <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          miso_q <= 1'b1;
          if (cs_fall) begin
            tx_shift_q <= tx_data;
            miso_q     <= tx_data[DATA_WIDTH-1];
            bit_cnt_q  <= '0;
            reload_q   <= 1'b0;
            state_q    <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (sclk_rise) begin
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
          end

          if (last_bit) begin
            done_q     <= 1'b1;
            tx_shift_q <= tx_data;
            reload_q   <= 1'b1;
          end else if (sclk_fall) begin
            if (reload_q) begin
              miso_q   <= tx_shift_q[DATA_WIDTH-1];
              reload_q <= 1'b0;
            end else begin
              tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
              miso_q     <= tx_shift_q[DATA_WIDTH-2];
            end
          end

          // Error judged on the count after this clk's rise, so a final
          // bit arriving together with cs rising completes cleanly.
          if (cs_rise) begin
            state_q   <= IDLE;
            miso_q    <= 1'b1;
            reload_q  <= 1'b0;
            bit_cnt_q <= '0;
            if (bit_cnt_d != '0) begin
              frame_err_q <= 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset, spi_clk, cs, mosi;
  logic       miso, rx_valid, busy, frame_err;
  logic [7:0] tx_data, rx_data;

  int total = 0;
  int bad   = 0;

  int         nvalid = 0;
  int         nerr   = 0;
  logic [7:0] rxlog [0:7];

  int         v0, e0;
  logic [7:0] mo, mi, mi2;
  logic       b;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .frame_err(frame_err)
  );

  // Pulse recorder, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (nvalid < 8) rxlog[nvalid] <= rx_data;
      nvalid <= nvalid + 1;
    end
    if (frame_err) nerr <= nerr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SPI bit, spi_clk = clk/4. Master drives mosi on the falling edge
  // and reads miso at the end of the high phase.
  task automatic bit_xfer(input logic m_o, output logic m_i);
    mosi = m_o;
    #20 spi_clk = 1'b1;
    #20 m_i = miso;
    spi_clk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] m_o, output logic [7:0] m_i);
    logic bb;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(m_o[i], bb);
      m_i[i] = bb;
    end
  endtask

  task automatic cs_start();
    cs = 1'b0;
    #40;
  endtask

  task automatic cs_end();
    #40 cs = 1'b1;
    #60;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0; tx_data = 8'h00;
    #20;
    check("rst_miso",      miso,      1);
    check("rst_rx_data",   rx_data,   0);
    check("rst_rx_valid",  rx_valid,  0);
    check("rst_busy",      busy,      0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    #40;

    // 1: single frame A5 in, 3C out, with latency check on rx_valid
    tx_data = 8'h3C; mo = 8'hA5; v0 = nvalid; e0 = nerr;
    cs_start();
    check("t1_busy", busy, 1);
    for (int i = 7; i >= 1; i--) begin
      bit_xfer(mo[i], b);
      mi[i] = b;
    end
    mosi = mo[0];
    #20 spi_clk = 1'b1;
    #20 mi[0] = miso;
    spi_clk = 1'b0;
    #10 check("t1_valid_early", rx_valid, 0);
    #10 check("t1_valid_lat4",  rx_valid, 1);
    check("t1_rx_data_at_valid", rx_data, 8'hA5);
    cs_end();
    check("t1_miso_word", mi,           8'h3C);
    check("t1_rx_data",   rx_data,      8'hA5);
    check("t1_nvalid",    nvalid - v0,  1);
    check("t1_nerr",      nerr - e0,    0);
    check("t1_busy_end",  busy,         0);
    check("t1_miso_idle", miso,         1);

    // 2: back-to-back frames, tx_data changed mid first frame
    tx_data = 8'h5A; v0 = nvalid; e0 = nerr;
    cs_start();
    mo = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) tx_data = 8'h81;
      bit_xfer(mo[i], b);
      mi[i] = b;
    end
    frame(8'hFE, mi2);
    cs_end();
    check("t2_nvalid",  nvalid - v0, 2);
    check("t2_rx0",     rxlog[v0],   8'h01);
    check("t2_rx1",     rxlog[v0+1], 8'hFE);
    check("t2_miso_w0", mi,          8'h5A);
    check("t2_miso_w1", mi2,         8'h81);
    check("t2_nerr",    nerr - e0,   0);

    // 3: aborted frame after 5 bits, then a good frame
    v0 = nvalid; e0 = nerr;
    cs_start();
    for (int i = 0; i < 5; i++) bit_xfer(1'b1, b);
    cs_end();
    check("t3_nerr",    nerr - e0,   1);
    check("t3_nvalid",  nvalid - v0, 0);
    check("t3_rx_hold", rx_data,     8'hFE);
    v0 = nvalid; e0 = nerr;
    cs_start();
    frame(8'h55, mi);
    cs_end();
    check("t3_rx_55",     rx_data,     8'h55);
    check("t3_nvalid_55", nvalid - v0, 1);
    check("t3_nerr_55",   nerr - e0,   0);

    // 4: final spi_clk rise coincident with cs rise
    v0 = nvalid; e0 = nerr; mo = 8'h96;
    cs_start();
    for (int i = 7; i >= 1; i--) bit_xfer(mo[i], b);
    mosi = mo[0];
    #20 spi_clk = 1'b1; cs = 1'b1;
    #40 spi_clk = 1'b0;
    #60;
    check("t4_nvalid", nvalid - v0, 1);
    check("t4_nerr",   nerr - e0,   0);
    check("t4_rx",     rx_data,     8'h96);
    check("t4_busy",   busy,        0);

    // 5: reset mid-frame with cs held low
    v0 = nvalid; e0 = nerr;
    cs_start();
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, b);
    reset = 1'b1;
    #20;
    check("t5_rst_busy",   busy,      0);
    check("t5_rst_miso",   miso,      1);
    check("t5_rst_rx",     rx_data,   0);
    check("t5_rst_valid",  rx_valid,  0);
    check("t5_rst_ferr",   frame_err, 0);
    reset = 1'b0;
    #20;
    for (int i = 0; i < 8; i++) bit_xfer(1'b1, b);
    #60;
    check("t5_nvalid_lowcs", nvalid - v0, 0);
    check("t5_busy_lowcs",   busy,        0);
    cs = 1'b1;
    #60;
    cs_start();
    frame(8'hC3, mi);
    cs_end();
    check("t5_rx_c3",  rx_data,     8'hC3);
    check("t5_nvalid", nvalid - v0, 1);
    check("t5_nerr",   nerr - e0,   0);

    // 6: spi_clk activity while deselected
    v0 = nvalid; e0 = nerr;
    for (int i = 0; i < 4; i++) bit_xfer(1'b0, b);
    check("t6_busy_mid", busy, 0);
    check("t6_miso_mid", miso, 1);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, b);
    #60;
    check("t6_nvalid", nvalid - v0, 0);
    check("t6_nerr",   nerr - e0,   0);
    check("t6_miso",   miso,        1);
    check("t6_rx",     rx_data,     8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
